// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 exception unit.
//   - CP0 register numbers (sel values) used by mfc0/mtc0
//   - SR / CAUSE field bit positions
//   - ExcCode values presented by the controller on exception entry
//   - pack_sr(): assembles the architecturally visible SR word
package cp0_pkg;

  localparam logic [4:0] SEL_COUNT   = 5'd9;
  localparam logic [4:0] SEL_COMPARE = 5'd11;
  localparam logic [4:0] SEL_SR      = 5'd12;
  localparam logic [4:0] SEL_CAUSE   = 5'd13;
  localparam logic [4:0] SEL_EPC     = 5'd14;
  localparam logic [4:0] SEL_PRID    = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 10;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LO +: 6] = im;
    w[SR_EXL]        = exl;
    w[SR_IE]         = ie;
    return w;
  endfunction

endpackage

// File: rtl/cp0_int_pend.sv
// cp0_int_pend: pending-interrupt tracker for one hardware interrupt line.
//   The raw line is registered once (hw_q). In level mode pend follows hw_q.
//   In edge mode a rising edge of hw_q sets a sticky pend bit that software
//   clears through clr; a set in the same cycle as a clear wins.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   hw        raw external interrupt line
//   clr       software clear strobe (edge mode only)
//   pend      registered pending bit (drives CAUSE.IP)
module cp0_int_pend #(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic hw,
  input  logic clr,
  output logic pend
);

  logic hw_q;
  logic hw_qq;

  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q  <= 1'b0;
      hw_qq <= 1'b0;
      pend  <= 1'b0;
    end else begin
      hw_q  <= hw;
      hw_qq <= hw_q;
      if (EDGE) begin
        if (hw_q && !hw_qq) pend <= 1'b1;
        else if (clr)       pend <= 1'b0;
      end else begin
        pend <= hw_q;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit: coprocessor 0 for the multi-cycle MIPS core.
//   SR (IM/EXL/IE), CAUSE (IP/ExcCode), EPC, PRID; NUM_HWINT interrupt lines
//   with per-line level/edge sensing; exception entry and ERET.
//   Update priority each cycle: rst > exc_enter > eret > wen (mtc0).
//   Optional timer (Count sel 9, Compare sel 11, IP[15]) under macro
//   CP0_TIMER_EN; without it sel 9/11 read 0 and writes are ignored.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wen, sel, din     mtc0 strobe, register number, write data
//   dout              mfc0 read data (combinational from sel)
//   hwint             external interrupt lines
//   exc_enter,        exception entry commit, its ExcCode and PC to save
//   exc_code, pc_cur
//   eret              ERET commit
//   intreq            interrupt request to the controller
//   exl_out, epc_out  SR.EXL and EPC
module cp0_exc_unit
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [5:0]  EDGE_MASK = 6'b000000,
  parameter logic [31:0] SR_RST    = 32'h0000_0401,
  parameter logic [31:0] PRID_VAL  = 32'h2107_4220
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wen,
  input  logic [4:0]           sel,
  input  logic [31:0]          din,
  output logic [31:0]          dout,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 exc_enter,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          pc_cur,
  input  logic                 eret,
  output logic                 intreq,
  output logic                 exl_out,
  output logic [31:0]          epc_out
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [4:0]  exc_q;
  logic [31:0] epc;
  logic [5:0]  ip_hw;
  logic [5:0]  ip;
  logic        timer_pend;
  logic [31:0] count_rd;
  logic [31:0] compare_rd;

  // mtc0 only takes effect when no higher-priority event owns the cycle.
  logic wen_ok;
  logic cause_wr;
  assign wen_ok   = wen & ~exc_enter & ~eret;
  assign cause_wr = wen_ok & (sel == SEL_CAUSE);

  for (genvar i = 0; i < 6; i++) begin : g_line
    if (i < NUM_HWINT) begin : g_used
      cp0_int_pend #(.EDGE(EDGE_MASK[i])) u_pend (
        .clk  (clk),
        .rst  (rst),
        .hw   (hwint[i]),
        .clr  (cause_wr & ~din[CAUSE_IP_LO + i]),
        .pend (ip_hw[i])
      );
    end else begin : g_unused
      assign ip_hw[i] = 1'b0;
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count;
  logic [31:0] compare;
  logic [31:0] count_nxt;
  logic [31:0] compare_nxt;
  logic        compare_wr;

  assign compare_wr  = wen_ok & (sel == SEL_COMPARE);
  assign count_nxt   = (wen_ok && sel == SEL_COUNT) ? din : count + 32'd1;
  assign compare_nxt = compare_wr ? din : compare;

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      compare    <= '1;
      timer_pend <= 1'b0;
    end else begin
      count   <= count_nxt;
      compare <= compare_nxt;
      // Match on the post-update values so a Count load that lands on
      // Compare raises the timer in that same cycle.
      if (count_nxt == compare_nxt) timer_pend <= 1'b1;
      else if (compare_wr)          timer_pend <= 1'b0;
    end
  end

  assign count_rd   = count;
  assign compare_rd = compare;
`else
  assign timer_pend = 1'b0;
  assign count_rd   = '0;
  assign compare_rd = '0;
`endif

  assign ip = ip_hw | {timer_pend, 5'b00000};

  always_ff @(posedge clk) begin
    if (rst) begin
      im    <= SR_RST[SR_IM_LO +: 6];
      exl   <= SR_RST[SR_EXL];
      ie    <= SR_RST[SR_IE];
      exc_q <= '0;
      epc   <= '0;
    end else if (exc_enter) begin
      exc_q <= exc_code;
      // Nested entry keeps the original return address.
      if (!exl) epc <= pc_cur;
      exl <= 1'b1;
    end else if (eret) begin
      exl <= 1'b0;
    end else if (wen) begin
      if (sel == SEL_SR) begin
        im  <= din[SR_IM_LO +: 6];
        exl <= din[SR_EXL];
        ie  <= din[SR_IE];
      end else if (sel == SEL_EPC) begin
        epc <= din;
      end
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_SR:      dout = pack_sr(im, exl, ie);
      SEL_CAUSE: begin
        dout[CAUSE_IP_LO +: 6]  = ip;
        dout[CAUSE_EXC_LO +: 5] = exc_q;
      end
      SEL_EPC:     dout = epc;
      SEL_PRID:    dout = PRID_VAL;
      SEL_COUNT:   dout = count_rd;
      SEL_COMPARE: dout = compare_rd;
      default:     dout = '0;
    endcase
  end

  assign intreq  = (|(ip & im)) & ie & ~exl;
  assign exl_out = exl;
  assign epc_out = epc;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Bench for cp0_exc_unit (EDGE_MASK = 6'b000100: line 2 edge, others level).
// A vector table drives one clock per record; after the edge the strobes are
// dropped, sel is switched to the record's read register and dout, intreq,
// exl_out and epc_out are compared. Hand sequences cover reset, same-cycle
// mfc0 of an mtc0 target, a write dropped under exc_enter, and the timer.
module tb_cp0_exc_unit;

  logic        clk;
  logic        rst;
  logic        wen;
  logic [4:0]  sel;
  logic [31:0] din;
  logic [31:0] dout;
  logic [5:0]  hwint;
  logic        exc_enter;
  logic [4:0]  exc_code;
  logic [31:0] pc_cur;
  logic        eret;
  logic        intreq;
  logic        exl_out;
  logic [31:0] epc_out;

  int n_checks = 0;
  int n_pass   = 0;

  cp0_exc_unit #(
    .NUM_HWINT(6),
    .EDGE_MASK(6'b000100),
    .SR_RST   (32'h0000_0401),
    .PRID_VAL (32'h2107_4220)
  ) dut (
    .clk(clk), .rst(rst), .wen(wen), .sel(sel), .din(din), .dout(dout),
    .hwint(hwint), .exc_enter(exc_enter), .exc_code(exc_code), .pc_cur(pc_cur),
    .eret(eret), .intreq(intreq), .exl_out(exl_out), .epc_out(epc_out)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] din;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] pc;
    logic        eret;
    logic [4:0]  rsel;
    logic [31:0] exp_dout;
    logic        exp_intreq;
    logic        exp_exl;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic w, logic [4:0] ws, logic [31:0] d,
                              logic [5:0] hw, logic exc, logic [4:0] code,
                              logic [31:0] pc, logic er, logic [4:0] rs,
                              logic [31:0] ed, logic ei, logic ex, logic [31:0] ep);
    vec_t v;
    v.name = name; v.wen = w; v.wsel = ws; v.din = d; v.hw = hw; v.exc = exc;
    v.code = code; v.pc = pc; v.eret = er; v.rsel = rs; v.exp_dout = ed;
    v.exp_intreq = ei; v.exp_exl = ex; v.exp_epc = ep;
    return v;
  endfunction

  // Scoreboard helper
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Driver tasks
  task automatic idle_inputs();
    wen = 1'b0; din = '0; exc_enter = 1'b0; exc_code = '0; pc_cur = '0; eret = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    wen = v.wen; sel = v.wsel; din = v.din; hwint = v.hw;
    exc_enter = v.exc; exc_code = v.code; pc_cur = v.pc; eret = v.eret;
    @(posedge clk);
    #2;
    idle_inputs();
    sel = v.rsel;
    #1;
    chk32({v.name, ".dout"},   dout,            v.exp_dout);
    chk32({v.name, ".intreq"}, {31'd0, intreq}, {31'd0, v.exp_intreq});
    chk32({v.name, ".exl"},    {31'd0, exl_out}, {31'd0, v.exp_exl});
    chk32({v.name, ".epc"},    epc_out,         v.exp_epc);
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    wen = 1'b1; sel = s; din = d;
    @(posedge clk);
    #2;
    idle_inputs();
  endtask

  logic [31:0] cnt_exp;

  initial begin
    rst = 1'b1; sel = '0; hwint = '0;
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    sel = 5'd12; #1; chk32("rst.sr",    dout, 32'h0000_0401);
    sel = 5'd13; #1; chk32("rst.cause", dout, 32'h0000_0000);
    sel = 5'd14; #1; chk32("rst.epc",   dout, 32'h0000_0000);
    sel = 5'd15; #1; chk32("rst.prid",  dout, 32'h2107_4220);
    chk32("rst.intreq", {31'd0, intreq}, 32'd0);
    chk32("rst.exl",    {31'd0, exl_out}, 32'd0);
    chk32("rst.epc_out", epc_out, 32'd0);

    //                   name    wen sel  din            hw  exc code pc   eret rsel expdout       irq exl epc
    vecs.push_back(mk("lvl_a",  0, 0,  0,             1,  0, 0,  0,       0, 12, 32'h0000_0401, 0, 0, 0));
    vecs.push_back(mk("lvl_b",  0, 0,  0,             1,  0, 0,  0,       0, 13, 32'h0000_0400, 1, 0, 0));
    vecs.push_back(mk("lvl_c",  0, 0,  0,             0,  0, 0,  0,       0, 13, 32'h0000_0400, 1, 0, 0));
    vecs.push_back(mk("lvl_d",  0, 0,  0,             0,  0, 0,  0,       0, 13, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk("im2",    1, 12, 32'h0000_1401, 0,  0, 0,  0,       0, 12, 32'h0000_1401, 0, 0, 0));
    vecs.push_back(mk("edg_a",  0, 0,  0,             4,  0, 0,  0,       0, 13, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk("edg_b",  0, 0,  0,             0,  0, 0,  0,       0, 13, 32'h0000_1000, 1, 0, 0));
    vecs.push_back(mk("edg_hold",0,0,  0,             0,  0, 0,  0,       0, 13, 32'h0000_1000, 1, 0, 0));
    vecs.push_back(mk("edg_clr",1, 13, 32'hFFFF_EFFF, 0,  0, 0,  0,       0, 13, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk("edg_c",  0, 0,  0,             4,  0, 0,  0,       0, 13, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk("set_win",1, 13, 32'h0000_0000, 0,  0, 0,  0,       0, 13, 32'h0000_1000, 1, 0, 0));
    vecs.push_back(mk("edg_clr2",1,13, 32'h0000_0000, 0,  0, 0,  0,       0, 13, 32'h0000_0000, 0, 0, 0));
    vecs.push_back(mk("enter",  0, 0,  0,             1,  1, 12, 32'h3008,0, 13, 32'h0000_0030, 0, 1, 32'h3008));
    vecs.push_back(mk("nested", 0, 0,  0,             1,  1, 4,  32'h4000,0, 14, 32'h0000_3008, 0, 1, 32'h3008));
    vecs.push_back(mk("masked", 0, 0,  0,             1,  0, 0,  0,       0, 13, 32'h0000_0410, 0, 1, 32'h3008));
    vecs.push_back(mk("eret_w", 1, 14, 32'h0000_1234, 1,  0, 0,  0,       1, 14, 32'h0000_3008, 1, 0, 32'h3008));
    vecs.push_back(mk("ent_er", 0, 0,  0,             0,  1, 0,  32'h5000,1, 12, 32'h0000_1403, 0, 1, 32'h5000));
    vecs.push_back(mk("eret2",  0, 0,  0,             0,  0, 0,  0,       1, 12, 32'h0000_1401, 0, 0, 32'h5000));
    vecs.push_back(mk("prid_w", 1, 15, 32'h0000_0000, 0,  0, 0,  0,       0, 15, 32'h2107_4220, 0, 0, 32'h5000));
`ifdef CP0_TIMER_EN
    vecs.push_back(mk("sel9",   1, 9,  32'h0000_ABCD, 0,  0, 0,  0,       0, 9,  32'h0000_ABCD, 0, 0, 32'h5000));
`else
    vecs.push_back(mk("sel9",   1, 9,  32'h0000_ABCD, 0,  0, 0,  0,       0, 9,  32'h0000_0000, 0, 0, 32'h5000));
`endif
    vecs.push_back(mk("unmap",  1, 20, 32'hFFFF_FFFF, 0,  0, 0,  0,       0, 20, 32'h0000_0000, 0, 0, 32'h5000));

    foreach (vecs[i]) apply(vecs[i]);

    // mfc0 in the same cycle as mtc0 returns the old value.
    wen = 1'b1; sel = 5'd14; din = 32'h0000_0077;
    #1;
    chk32("same_cyc.old", dout, 32'h0000_5000);
    @(posedge clk);
    #2;
    idle_inputs();
    #1;
    chk32("same_cyc.new", dout, 32'h0000_0077);
    chk32("same_cyc.epc_out", epc_out, 32'h0000_0077);

    // SR write loses to exception entry in the same cycle.
    wen = 1'b1; sel = 5'd12; din = 32'h0; exc_enter = 1'b1; exc_code = 5'd10;
    pc_cur = 32'h0000_0088;
    @(posedge clk);
    #2;
    idle_inputs();
    #1;
    chk32("drop.sr", dout, 32'h0000_1403);
    chk32("drop.epc", epc_out, 32'h0000_0088);
    eret = 1'b1;
    @(posedge clk);
    #2;
    idle_inputs();
    sel = 5'd12;
    #1;
    chk32("drop.eret_sr", dout, 32'h0000_1401);

`ifdef CP0_TIMER_EN
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    mtc0(5'd9,  32'd5);
    sel = 5'd9; #1;
    chk32("tmr.count", dout, 32'd5);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #3;
    end
    sel = 5'd13; #1;
    chk32("tmr.pre", dout, 32'h0000_0028);
    @(posedge clk);
    #3;
    chk32("tmr.ip15", dout, 32'h0000_8028);
    chk32("tmr.intreq", {31'd0, intreq}, 32'd1);
    mtc0(5'd11, 32'd0);
    sel = 5'd13; #1;
    chk32("tmr.clr", dout, 32'h0000_0028);
    chk32("tmr.intreq_clr", {31'd0, intreq}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
